// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage pipeline controller. An instruction arriving from EX (IR3_in)
// either passes straight through to the WB-stage register (IR4Wire_out) one
// cycle later, or, when it is a load/store, is parked in a hold register while
// the data memory access is in flight. During that access the block stalls
// upstream and emits bubbles (8'h0A) towards WB until mem_ready completes it.
//
// Optional feature, selected by the macro MEM_STAGE_TIMEOUT_EN:
//   a 4-bit wait counter aborts an access that sees no mem_ready for 16
//   MEM_WAIT cycles and sets the sticky mem_err flag. Without the macro the
//   access waits indefinitely and mem_err is tied to 0.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   IR3_in       in   [7:0] instruction from EX, opcode in [3:0]
//   ir3_valid    in   IR3_in carries a real instruction
//   mem_ready    in   data memory completes the current access
//   MemRead      out  read strobe (MEM_WAIT with a held load)
//   MemWrite     out  write strobe (MEM_WAIT with a held store)
//   stall_out    out  upstream must hold IR3_in/ir3_valid
//   IR4Wire_out  out  [7:0] instruction register feeding WB
//   ir4_valid    out  IR4Wire_out carries a real instruction
//   mem_err      out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module mem_stage_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IR3_in,
    input  logic       ir3_valid,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       stall_out,
    output logic [7:0] IR4Wire_out,
    output logic       ir4_valid,
    output logic       mem_err
);

    localparam logic [7:0] BUBBLE   = 8'h0A;
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [7:0] hold_reg;
    logic [7:0] ir4_reg;
    logic       ir4_valid_reg;

    logic       in_is_mem;
    assign in_is_mem = (IR3_in[3:0] == OP_LOAD) || (IR3_in[3:0] == OP_STORE);

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [3:0] wait_cnt_reg;
    logic       mem_err_reg;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            hold_reg      <= BUBBLE;
            ir4_reg       <= BUBBLE;
            ir4_valid_reg <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            wait_cnt_reg  <= 4'd0;
            mem_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                RUN: begin
                    // mem_ready is deliberately not looked at here.
                    if (ir3_valid && in_is_mem) begin
                        hold_reg      <= IR3_in;
                        state_reg     <= MEM_WAIT;
                        ir4_reg       <= BUBBLE;
                        ir4_valid_reg <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
                        wait_cnt_reg  <= 4'd0;
`endif
                    end else if (ir3_valid) begin
                        ir4_reg       <= IR3_in;
                        ir4_valid_reg <= 1'b1;
                    end else begin
                        ir4_reg       <= BUBBLE;
                        ir4_valid_reg <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        // Completion wins over a timeout on the same edge.
                        ir4_reg       <= hold_reg;
                        ir4_valid_reg <= 1'b1;
                        state_reg     <= RUN;
                    end else begin
                        ir4_reg       <= BUBBLE;
                        ir4_valid_reg <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
                        // Counter reads 15 on the 16th cycle without ready.
                        if (wait_cnt_reg == 4'd15) begin
                            state_reg   <= RUN;
                            mem_err_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_reg     <= RUN;
                    ir4_reg       <= BUBBLE;
                    ir4_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Strobes and stall are pure decodes of registered state.
    assign stall_out   = (state_reg == MEM_WAIT);
    assign MemRead     = (state_reg == MEM_WAIT) && (hold_reg[3:0] == OP_LOAD);
    assign MemWrite    = (state_reg == MEM_WAIT) && (hold_reg[3:0] == OP_STORE);
    assign IR4Wire_out = ir4_reg;
    assign ir4_valid   = ir4_valid_reg;

`ifdef MEM_STAGE_TIMEOUT_EN
    assign mem_err = mem_err_reg;
`else
    assign mem_err = 1'b0;
`endif

endmodule
